// File: rtl/timer_arb_pkg.sv
// timer_arb_pkg: shared FSM state type and default sizes for timer_arbiter
package timer_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int CW_DEF = 4;
  localparam int NREQ_DEF = 4;
endpackage

// File: rtl/timer_core.sv
// timer_core: async-reset up-counter cleared by load, stepped by en; hit flags count==tc
//   clk, reset : clock and asynchronous active-high reset
//   load, en   : clear to zero (wins over en) / increment
//   tc         : terminal count compared against count
//   count, hit : live value and combinational terminal-count match
module timer_core #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] tc,
  output logic [CW-1:0] count,
  output logic          hit
);
  assign hit = count == tc;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= '0;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin scheduler sharing one interval timer between NREQ requesters
//   clk, reset : clock and asynchronous active-high reset
//   pause      : present only with TIMER_ARB_PAUSE_EN; freezes the RUN state and counter
//   req, len   : request levels and packed per-requester terminal counts
//   gnt, done  : one-hot grant (LOAD..DONE) and one-cycle completion pulse
//   busy, owner, count : non-IDLE flag, current/last owner index, live timer value
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW = CW_DEF,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef TIMER_ARB_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [IDW-1:0]     owner,
  output logic [CW-1:0]      count
);
  state_t state;
  logic [IDW-1:0] last, sel, j;
  logic [NREQ-1:0] oh;
  logic [CW-1:0] tc;
  logic [CW-1:0] lens [NREQ];
  logic hit, abort, hold;
`ifdef TIMER_ARB_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  always_comb
    for (int i = 0; i < NREQ; i++) lens[i] = len[i*CW +: CW];
  // Scan downward so the nearest requester after last is the one left in sel.
  always_comb begin
    sel = '0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IDW'((int'(last) + k) % NREQ);
      if (req[j]) sel = j;
    end
  end
  always_comb begin
    oh = '0;
    oh[sel] = 1'b1;
  end
  assign abort = (state == LOAD || state == RUN) && !req[owner];
  timer_core #(.CW(CW)) u_core (
    .clk(clk),
    .reset(reset),
    .load(state == LOAD || abort),
    .en(state == RUN && !hit && !hold),
    .tc(tc),
    .count(count),
    .hit(hit)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      done <= '0;
      busy <= 1'b0;
      owner <= '0;
      last <= IDW'(NREQ - 1);
      tc <= '0;
    end else begin
      done <= '0;
      if (abort) begin
        state <= IDLE;
        gnt <= '0;
        busy <= 1'b0;
      end else
        case (state)
          IDLE: if (|req) begin
            owner <= sel;
            last <= sel;
            gnt <= oh;
            busy <= 1'b1;
            state <= LOAD;
          end
          LOAD: begin
            tc <= lens[owner];
            state <= RUN;
          end
          RUN: if (hit && !hold) begin
            done <= gnt;
            state <= DONE;
          end
          default: begin
            gnt <= '0;
            busy <= 1'b0;
            state <= IDLE;
          end
        endcase
    end
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: scoreboard bench; expected done vectors and latencies queued at stimulus time
module tb_timer_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] req = '0;
  logic [15:0] len = '0;
  logic [3:0] gnt, done;
  logic busy;
  logic [1:0] owner;
  logic [3:0] count;
`ifdef TIMER_ARB_PAUSE_EN
  logic pause = 1'b0;
`endif
  typedef struct {logic [3:0] d; int lat;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int cyc = 0, g_cyc = 0, done_cyc = 0;
  logic [3:0] prev_gnt = '0, prev_done = '0;
  logic gap_on = 1'b0;
  timer_arbiter dut (
    .clk(clk),
    .reset(reset),
`ifdef TIMER_ARB_PAUSE_EN
    .pause(pause),
`endif
    .req(req),
    .len(len),
    .gnt(gnt),
    .done(done),
    .busy(busy),
    .owner(owner),
    .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic push(input logic [3:0] d, input int lat);
    exp_t e;
    e.d = d;
    e.lat = lat;
    q.push_back(e);
  endtask
  task automatic wait_gnt;
    for (int i = 0; i < 40 && gnt == 0; i++) tick;
    chk("gnt_seen", int'(gnt != 0), 1);
  endtask
  task automatic wait_count(input int v);
    for (int i = 0; i < 40 && int'(count) != v; i++) tick;
    chk("count_seen", count, v);
  endtask
  task automatic wait_empty;
    for (int i = 0; i < 80 && q.size() != 0; i++) tick;
    chk("drain", q.size(), 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (gnt != 0 && prev_gnt == 0) begin
      if (gap_on) chk("idle_gap", cyc - done_cyc, 2);
      g_cyc = cyc;
    end
    if (prev_done != 0) chk("done_pulse", done, 0);
    if (done != 0) begin
      if (q.size() == 0) chk("spurious_done", done, 0);
      else begin
        e = q.pop_front();
        chk("done_vec", done, e.d);
        chk("done_lat", cyc - g_cyc, e.lat);
      end
      chk("done_owner", done, gnt);
      done_cyc = cyc;
    end
    prev_gnt = gnt;
    prev_done = done;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int mx;
    tick;
    tick;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_owner", owner, 0);
    reset = 1'b0;
    tick;
    len = {4'd0, 4'd0, 4'd0, 4'd3};
    req = 4'b0001;
    push(4'b0001, 5);
    tick;
    chk("s1_gnt", gnt, 4'b0001);
    chk("s1_busy", busy, 1);
    chk("s1_owner", owner, 0);
    tick;
    chk("s1_cnt0", count, 0);
    tick;
    chk("s1_cnt1", count, 1);
    tick;
    tick;
    chk("s1_cnt3", count, 3);
    tick;
    chk("s1_done", done, 4'b0001);
    req = 4'b0000;
    tick;
    chk("s1_gnt_off", gnt, 0);
    chk("s1_busy_off", busy, 0);
    chk("s1_cnt_hold", count, 3);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    len = {4'd1, 4'd1, 4'd1, 4'd1};
    req = 4'b1111;
    push(4'b0001, 3);
    push(4'b0010, 3);
    push(4'b0100, 3);
    push(4'b1000, 3);
    push(4'b0001, 3);
    for (int i = 0; i < 40 && q.size() > 4; i++) tick;
    gap_on = 1'b1;
    wait_empty;
    req = 4'b0000;
    gap_on = 1'b0;
    len = {4'd1, 4'd1, 4'd1, 4'd0};
    req = 4'b0001;
    push(4'b0001, 2);
    wait_empty;
    req = 4'b0000;
    tick;
    tick;
    len = {4'd1, 4'd1, 4'd1, 4'd15};
    req = 4'b0001;
    push(4'b0001, 17);
    mx = 0;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      tick;
      if (int'(count) > mx && gnt != 0) mx = count;
    end
    chk("s3_drain", q.size(), 0);
    chk("s3_max", mx, 15);
    chk("s3_end", count, 15);
    req = 4'b0000;
    tick;
    tick;
    len = {4'd2, 4'd8, 4'd0, 4'd15};
    req = 4'b1100;
    wait_gnt;
    chk("s4_gnt", gnt, 4'b0100);
    chk("s4_owner", owner, 2);
    wait_count(4);
    req = 4'b1000;
    tick;
    chk("s4_abort_gnt", gnt, 0);
    chk("s4_abort_cnt", count, 0);
    chk("s4_abort_busy", busy, 0);
    push(4'b1000, 4);
    tick;
    chk("s4_next_gnt", gnt, 4'b1000);
    chk("s4_next_owner", owner, 3);
    wait_empty;
    req = 4'b0000;
    tick;
    tick;
    len = {4'd0, 4'd0, 4'd1, 4'd8};
    req = 4'b0001;
    wait_gnt;
    wait_count(5);
    reset = 1'b1;
    #1;
    chk("s5_gnt", gnt, 0);
    chk("s5_done", done, 0);
    chk("s5_busy", busy, 0);
    chk("s5_count", count, 0);
    tick;
    reset = 1'b0;
    req = 4'b1010;
    push(4'b0010, 3);
    tick;
    chk("s5_gnt1", gnt, 4'b0010);
    chk("s5_owner1", owner, 1);
    wait_empty;
    req = 4'b0000;
`ifdef TIMER_ARB_PAUSE_EN
    tick;
    tick;
    len = {4'd0, 4'd0, 4'd0, 4'd4};
    req = 4'b0001;
    push(4'b0001, 9);
    wait_count(2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("p_hold", count, 2);
    end
    pause = 1'b0;
    wait_empty;
    req = 4'b0000;
`endif
    tick;
    tick;
    tick;
    chk("end_queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one 4-bit up-counter timer between NREQ requesters.
- Each requester asks for an interval of `len` cycles; a round-robin arbiter grants the timer, loads the terminal count, runs it and pulses `done` to the owner.
- Sits above the existing free-running counter block and turns it into a scheduled, shared resource.

Parameters:
- NREQ, 4, number of requesters (≥2).
- CW, 4, counter/terminal-count width.
- IDW, $clog2(NREQ), localparam; owner index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until `done`.
- len  in  NREQ*CW  packed terminal counts; requester i at [i*CW +: CW].
- gnt  out  NREQ  one-hot grant; high from LOAD through DONE.
- done  out  NREQ  one-cycle completion pulse to the owner.
- busy  out  1  high in any state except IDLE.
- owner  out  IDW  index of the current/last granted requester.
- count  out  CW  live timer value.

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-run):
  - state=IDLE; gnt=0, done=0, busy=0, count=0, owner=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has highest priority first.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If req≠0, select the first set req scanning last+1, last+2, … (mod NREQ).
  - Set owner, gnt[owner]=1, busy=1, last=owner; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle): tc<=len[owner], count<=0; go to RUN.
- RUN:
  - If count==tc: go to DONE and hold count.
  - Else: count<=count+1.
  - RUN lasts tc+1 cycles. tc=0 is legal (1 RUN cycle); tc=15 gives max 16 cycles. No wrap past tc.
- DONE (1 cycle): done[owner]=1. Next edge: gnt=0, done=0, busy=0, go to IDLE. count holds its final value until the next LOAD.
- Latency, from the cycle gnt rises to the cycle done is high: tc+2 cycles.
- Abort:
  - If req[owner] drops during LOAD or RUN: go to IDLE next edge, gnt=0, count=0, no done pulse.
  - The pointer still advances (last=owner).
- Fairness:
  - A requester holding req after its done is rescheduled only after other pending requesters.
  - A single requester re-wins immediately, with one IDLE cycle between jobs.
- Requests arriving in non-IDLE states wait; `len` is sampled only in LOAD.

Optional Feature:
- Macro: TIMER_ARB_PAUSE_EN.
- Defined:
  - Adds input port `pause` (1 bit).
  - While pause=1 in RUN: count and state hold.
  - pause is ignored in other states.
  - Abort on req drop still applies during pause.
- Undefined: no `pause` port; RUN always advances every cycle.

Decomposition:
- Package timer_arb_pkg: state enum (IDLE, LOAD, RUN, DONE); default CW=4 and NREQ=4 constants.
- Sub-module timer_core:
  - Ports: clk, reset, load, en, tc[CW], count[CW], hit.
  - hit = (count==tc), combinational.
  - Async-reset loadable up-counter, instantiated once.
- Arbitration and FSM stay in timer_arbiter.

Test Plan:
- Reset then req=0001, len0=3 -> gnt=0001 the cycle after req is sampled; count runs 0,1,2,3; done=0001 for exactly 1 cycle, 5 cycles after gnt rose; busy falls with gnt.
- req=1111 held continuously, all len=1 -> grant order 0,1,2,3,0; each done one-hot matches owner; one IDLE cycle between jobs.
- req0 with len0=0 -> RUN 1 cycle; done 2 cycles after gnt. Then len0=15 -> count reaches 15, no wrap, done 17 cycles after gnt.
- req2 granted, len2=8, req2 dropped when count=4 -> next cycle IDLE, gnt=0, count=0, no done; a pending req3 is granted next.
- Assert reset when count=5 -> immediately gnt=0, done=0, busy=0, count=0. After release, req=1010 -> owner=1 granted first.
- TIMER_ARB_PAUSE_EN defined, len=4, pause=1 for 3 cycles at count=2 -> count holds at 2; done is delayed by exactly 3 cycles (tc+2+3 = 9 after gnt).
